// File: rtl/input_event_pkg.sv
// Shared register map, bit positions and the queued event record for the
// input event stamper.
package input_event_pkg;

  localparam int MAX_CH = 7;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_POP    = 3'd2;
  localparam logic [2:0] REG_TS_HI  = 3'd3;
  localparam logic [2:0] REG_TS_LO  = 3'd4;
  localparam logic [2:0] REG_NOW_HI = 3'd5;
  localparam logic [2:0] REG_NOW_LO = 3'd6;

  localparam int CTRL_IRQ_EN   = 15;
  localparam int CTRL_CLR      = 14;
  localparam int CTRL_FALL_LSB = 7;
  localparam int CTRL_RISE_LSB = 0;

  localparam int STAT_OVF     = 15;
  localparam int STAT_FULL    = 14;
  localparam int STAT_EMPTY   = 13;
  localparam int STAT_CNT_LSB = 8;

  typedef struct packed {
    logic [MAX_CH-1:0] rise;
    logic [MAX_CH-1:0] fall;
    logic [31:0]       stamp;
  } event_t;

  // STATUS only has five bits for the occupancy, so larger depths pin at 31.
  function automatic logic [4:0] sat_count5(input logic [31:0] n);
    return (n > 32'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

// File: rtl/input_event_stamper_if.sv
// Word-wide 68000-side bus into the event stamper's register file.
interface input_event_stamper_if;
  logic        sel;
  logic        rd;
  logic [1:0]  wr;
  logic [2:0]  address;
  logic [15:0] din;
  logic [15:0] dout;

  modport master (output sel, rd, wr, address, din, input dout);
  modport slave  (input sel, rd, wr, address, din, output dout);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; a pop frees a slot
// for a push on the same edge when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/input_event_stamper.sv
// Timestamps synchronised edges on the user input pins against a free-running
// cycle counter and queues them for the CPU to drain through a register window.
module input_event_stamper
  import input_event_pkg::*;
#(
  parameter int CHANNELS = 7,
  parameter int DEPTH    = 16,
  parameter int DROP_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CHANNELS-1:0]  pins,
  input_event_stamper_if.slave bus,
  output logic                 irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [MAX_CH-1:0] CH_MASK = MAX_CH'((1 << CHANNELS) - 1);

  logic [31:0]       counter_q;
  logic [MAX_CH-1:0] sync1_q, sync2_q, hist_q;
  logic [MAX_CH-1:0] ev_rise_q, ev_fall_q;
  logic [MAX_CH-1:0] rise_en_q, fall_en_q;
  logic              irq_en_q, irq_q;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic [31:0]       hold_stamp_q;
  logic [15:0]       now_lo_q;

  logic [MAX_CH-1:0] pins_w, rise_det, fall_det;
  logic              ev_valid, rd_stb, ctrl_wr, pop_req, now_rd, clear, drop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  event_t            push_ev, head_ev;

  assign pins_w   = MAX_CH'(pins);
  assign rise_det = sync2_q & ~hist_q & rise_en_q;
  assign fall_det = ~sync2_q & hist_q & fall_en_q;
  assign ev_valid = |{ev_rise_q, ev_fall_q};
  // The stamp is the counter value in the cycle the registered edge is presented.
  assign push_ev  = '{rise: ev_rise_q, fall: ev_fall_q, stamp: counter_q};

  assign rd_stb  = bus.sel & bus.rd;
  assign ctrl_wr = bus.sel & (bus.address == REG_CTRL);
  assign pop_req = rd_stb & (bus.address == REG_POP) & ~fifo_empty;
  assign now_rd  = rd_stb & (bus.address == REG_NOW_HI);
  assign clear   = ctrl_wr & bus.wr[1] & bus.din[CTRL_CLR];
  assign drop    = ev_valid & fifo_full & ~pop_req;

  sync_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (ev_valid),
    .wdata_i (push_ev),
    .pop_i   (pop_req),
    .rdata_o (head_ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    overflow_d = clear ? 1'b0 : overflow_q;
    dropped_d  = clear ? '0 : dropped_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (~&dropped_d) dropped_d = dropped_d + DROP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q    <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      hist_q       <= '0;
      ev_rise_q    <= '0;
      ev_fall_q    <= '0;
      irq_q        <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
      hold_stamp_q <= '0;
      now_lo_q     <= '0;
    end else begin
      counter_q  <= counter_q + 32'd1;
      sync1_q    <= pins_w;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      ev_rise_q  <= rise_det;
      ev_fall_q  <= fall_det;
      irq_q      <= irq_en_q & ~fifo_empty;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
      if (pop_req) hold_stamp_q <= head_ev.stamp;
      if (now_rd)  now_lo_q     <= counter_q[15:0];
    end
  end

  // fall_en straddles the byte lanes: bits [6:1] sit in the upper byte, bit 0 in the lower.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q  <= 1'b0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (ctrl_wr) begin
      if (bus.wr[1]) begin
        irq_en_q       <= bus.din[CTRL_IRQ_EN];
        fall_en_q[6:1] <= bus.din[13:8] & CH_MASK[6:1];
      end
      if (bus.wr[0]) begin
        fall_en_q[0] <= bus.din[CTRL_FALL_LSB] & CH_MASK[0];
        rise_en_q    <= bus.din[CTRL_RISE_LSB +: MAX_CH] & CH_MASK;
      end
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.address)
      REG_STATUS: bus.dout = {overflow_q, fifo_full, fifo_empty,
                              sat_count5(32'(fifo_count)), 8'(dropped_q)};
      REG_CTRL:   bus.dout = {irq_en_q, 1'b0, fall_en_q, rise_en_q};
      REG_POP:    bus.dout = fifo_empty ? 16'h0000
                                        : {1'b1, head_ev.fall, 1'b0, head_ev.rise};
      REG_TS_HI:  bus.dout = hold_stamp_q[31:16];
      REG_TS_LO:  bus.dout = hold_stamp_q[15:0];
      REG_NOW_HI: bus.dout = counter_q[31:16];
      REG_NOW_LO: bus.dout = now_lo_q;
      default:    bus.dout = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
